fpadd_seq: RTL

FPADD_SEQ -- requirements
Module: fpadd_seq

---
 rtl/fpadd_seq_if.sv | 14 +
 rtl/fpadd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fpadd_seq_if.sv
// Handshake and data bundle for the sequential single-precision adder.
// master: the requester driving operands; slave: the adder itself.
interface fpadd_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (output start, a, b, input busy, done, result, flags);
  modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fpadd_seq.sv
// Multi-cycle IEEE-754 single-precision adder, truncating rounding.
// Optional build macro FPADD_SPECIAL_EN: NaN/infinity inputs bypass the
// datapath from UNPACK straight to PACK. Without it, exponent 255 is just
// a large exponent and overflow saturates to infinity in PACK.
//
// state  | meaning
// IDLE   | waiting for start, operands latched on accept
// UNPACK | decode fields, order operands by magnitude, load align count
// ALIGN  | shift smaller significand right, one bit per cycle
// ADD    | 25-bit add or subtract of significands
// NORM   | carry fix-up or left-normalise one bit per cycle
// PACK   | assemble result word and flags
// DONE   | one-cycle done pulse
module fpadd_seq (
  input  logic        clk,
  input  logic        reset,
  fpadd_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic        busy_c, done_c;

  logic [31:0] op_a, op_b;
  logic        sign_l, sign_s;
  logic [23:0] sig_l, sig_s;
  logic [7:0]  diff;
  logic [24:0] sum;
  logic [9:0]  exp_r;
  logic        spec_valid;
  logic [31:0] spec_res_r;
  logic [31:0] result_r;
  logic [2:0]  flags_r;

  // Operand ordering; raw magnitude bits compare correctly including denormals.
  logic        a_ge;
  logic [31:0] op_l, op_s;
  logic [7:0]  el_u, es_u, diff_u;
  assign a_ge   = (op_a[30:0] >= op_b[30:0]);
  assign op_l   = a_ge ? op_a : op_b;
  assign op_s   = a_ge ? op_b : op_a;
  assign el_u   = (op_l[30:23] == 8'd0) ? 8'd1 : op_l[30:23];
  assign es_u   = (op_s[30:23] == 8'd0) ? 8'd1 : op_s[30:23];
  assign diff_u = el_u - es_u;

  logic        special_hit;
  logic [31:0] spec_res;
`ifdef FPADD_SPECIAL_EN
  logic nan_a, nan_b, inf_a, inf_b;
  assign nan_a = (&op_a[30:23]) && (|op_a[22:0]);
  assign nan_b = (&op_b[30:23]) && (|op_b[22:0]);
  assign inf_a = (&op_a[30:23]) && !(|op_a[22:0]);
  assign inf_b = (&op_b[30:23]) && !(|op_b[22:0]);
  assign special_hit = nan_a | nan_b | inf_a | inf_b;
  assign spec_res = (nan_a || nan_b || (inf_a && inf_b && (op_a[31] != op_b[31])))
                    ? 32'h7FC0_0000 : (inf_a ? op_a : op_b);
`else
  assign special_hit = 1'b0;
  assign spec_res    = 32'h0000_0000;
`endif

  logic norm_shl;
  assign norm_shl = !sum[23] && (sum != 25'd0) && (exp_r > 10'd1);

  // Assemble the packed result from the normalised sum.
  logic [31:0] pack_res;
  always_comb begin
    pack_res = {sign_l, exp_r[7:0], sum[22:0]};
    if (spec_valid)
      pack_res = spec_res_r;
    else if (exp_r >= 10'd255)
      pack_res = {sign_l, 8'hFF, 23'd0};
    else if (sum == 25'd0)
      pack_res = 32'h0000_0000;
    else if (!sum[23])
      pack_res = {sign_l, 8'h00, sum[22:0]};
  end

  function automatic logic [2:0] classify(input logic [31:0] v);
    logic zero_f, inf_f, nan_f;
    zero_f = (v[30:0] == 31'd0);
    inf_f  = (&v[30:23]) && (v[22:0] == 23'd0);
    nan_f  = (&v[30:23]) && (v[22:0] != 23'd0);
    return {zero_f, inf_f, nan_f};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy_c   = 1'b1;
    done_c   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nx = S_UNPACK;
      end
      S_UNPACK: begin
        if (special_hit)          state_nx = S_PACK;
        else if (diff_u == 8'd0)  state_nx = S_ADD;
        else                      state_nx = S_ALIGN;
      end
      S_ALIGN: if (diff >= 8'd25 || diff == 8'd1) state_nx = S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM: begin
        if (sum[24])       state_nx = S_PACK;
        else if (norm_shl) state_nx = S_NORM;
        else               state_nx = S_PACK;
      end
      S_PACK:  state_nx = S_DONE;
      S_DONE: begin
        done_c   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath registers, advanced by the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      sign_l     <= 1'b0;
      sign_s     <= 1'b0;
      sig_l      <= 24'd0;
      sig_s      <= 24'd0;
      diff       <= 8'd0;
      sum        <= 25'd0;
      exp_r      <= 10'd0;
      spec_valid <= 1'b0;
      spec_res_r <= 32'd0;
      result_r   <= 32'd0;
      flags_r    <= 3'b100;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_a       <= bus.a;
            op_b       <= bus.b;
            spec_valid <= 1'b0;
          end
        end
        S_UNPACK: begin
          sign_l     <= op_l[31];
          sign_s     <= op_s[31];
          sig_l      <= {|op_l[30:23], op_l[22:0]};
          sig_s      <= {|op_s[30:23], op_s[22:0]};
          diff       <= diff_u;
          exp_r      <= {2'b00, el_u};
          spec_valid <= special_hit;
          spec_res_r <= spec_res;
        end
        S_ALIGN: begin
          if (diff >= 8'd25) begin
            sig_s <= 24'd0;
            diff  <= 8'd0;
          end else begin
            sig_s <= sig_s >> 1;
            diff  <= diff - 8'd1;
          end
        end
        S_ADD: begin
          if (sign_l == sign_s) sum <= {1'b0, sig_l} + {1'b0, sig_s};
          else                  sum <= {1'b0, sig_l} - {1'b0, sig_s};
        end
        S_NORM: begin
          if (sum[24]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + 10'd1;
          end else if (norm_shl) begin
            sum   <= sum << 1;
            exp_r <= exp_r - 10'd1;
          end
        end
        S_PACK: begin
          result_r <= pack_res;
          flags_r  <= classify(pack_res);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_r;
  assign bus.flags  = flags_r;

endmodule
